// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM state definitions for the sequential ALU.
package alu_pkg;

    localparam logic [4:0] OP_A    = 5'd0;
    localparam logic [4:0] OP_B    = 5'd1;
    localparam logic [4:0] OP_NOTA = 5'd2;
    localparam logic [4:0] OP_NOTB = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADC  = 5'd5;
    localparam logic [4:0] OP_SUB  = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_XOR  = 5'd9;
    localparam logic [4:0] OP_NAND = 5'd10;
    localparam logic [4:0] OP_LSL  = 5'd11;
    localparam logic [4:0] OP_LSR  = 5'd12;
    localparam logic [4:0] OP_ASR  = 5'd13;
    localparam logic [4:0] OP_CSL  = 5'd14;
    localparam logic [4:0] OP_CSR  = 5'd15;
    localparam logic [4:0] OP_MUL  = 5'd16;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_O = 0;

    typedef enum logic {StIdle, StMulRun} state_e;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational result and flag evaluation for the single-cycle opcodes.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [4:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       flags_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       flags_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_new;
    logic             o_new;
    logic             upd_zn;

    always_comb begin
        sum    = '0;
        res    = '0;
        c_new  = flags_i[FLAG_C];
        o_new  = flags_i[FLAG_O];
        upd_zn = 1'b1;
        case (op_i)
            OP_A:    res = a_i;
            OP_B:    res = b_i;
            OP_NOTA: res = ~a_i;
            OP_NOTB: res = ~b_i;
            OP_ADD: begin
                sum   = {1'b0, a_i} + {1'b0, b_i};
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                o_new = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_ADC: begin
                sum   = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, flags_i[FLAG_C]};
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                o_new = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // Carry out of A + ~B + 1 is the inverted borrow.
                sum   = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                o_new = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND:  res = a_i & b_i;
            OP_OR:   res = a_i | b_i;
            OP_XOR:  res = a_i ^ b_i;
            OP_NAND: res = ~(a_i & b_i);
            OP_LSL: begin
                res   = {a_i[WIDTH-2:0], 1'b0};
                c_new = a_i[WIDTH-1];
            end
            OP_LSR: begin
                res   = {1'b0, a_i[WIDTH-1:1]};
                c_new = a_i[0];
            end
            OP_ASR: begin
                res   = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
                c_new = a_i[0];
            end
            OP_CSL: begin
                res   = {a_i[WIDTH-2:0], flags_i[FLAG_C]};
                c_new = a_i[WIDTH-1];
            end
            OP_CSR: begin
                res   = {flags_i[FLAG_C], a_i[WIDTH-1:1]};
                c_new = a_i[0];
            end
            default: upd_zn = 1'b0;
        endcase

        flags_o = flags_i;
        if (upd_zn) begin
            flags_o[FLAG_Z] = (res == '0);
            flags_o[FLAG_N] = res[WIDTH-1];
            flags_o[FLAG_C] = c_new;
            flags_o[FLAG_O] = o_new;
        end
        result_o = res;
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU: single-cycle ops via alu_comb_core, iterative shift-add MUL.
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             Start,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CntW = $clog2(MUL_CYCLES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MUL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [3:0]       flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             wf_q, wf_d;

    logic [WIDTH-1:0] core_res;
    logic [3:0]       core_flags;
    logic [WIDTH-1:0] acc_add;

    alu_comb_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_i    (FunSel),
        .a_i     (A),
        .b_i     (B),
        .flags_i (flags_q),
        .result_o(core_res),
        .flags_o (core_flags)
    );

    assign acc_add = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d   = state_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        wf_d      = wf_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    if (FunSel == OP_MUL) begin
                        mcand_d  = A;
                        mplier_d = B;
                        acc_d    = '0;
                        cnt_d    = '0;
                        wf_d     = WF;
                        busy_d   = 1'b1;
                        state_d  = StMulRun;
                    end else begin
                        // Reserved ops return 0 and core_flags == flags_q for them.
                        alu_out_d = core_res;
                        if (WF) flags_d = core_flags;
                        done_d = 1'b1;
                    end
                end
            end
            StMulRun: begin
                acc_d    = acc_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    alu_out_d = acc_add;
                    if (wf_q) begin
                        flags_d[FLAG_Z] = (acc_add == '0);
                        flags_d[FLAG_N] = acc_add[WIDTH-1];
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            alu_out_q <= '0;
            flags_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            wf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            wf_q      <= wf_d;
        end
    end

    assign ALUOut   = alu_out_q;
    assign FlagsOut = flags_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
